// File: rtl/syn_vcortex_pkg.sv
// Shared types and constants for the vcortex SRAM arbiter slice.
package syn_vcortex_pkg;

  localparam int SRAM_ADDR_W = 18;
  localparam int SRAM_DATA_W = 16;
  // Wide enough for the largest legal VGA burst limit (15).
  localparam int BURST_CNT_W = 4;

  typedef enum logic [1:0] {
    ARB_VGA = 2'd0,
    ARB_GPU = 2'd1,
    ARB_LB  = 2'd2
  } arb_id_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    END  = 2'd2
  } sram_arb_fsm_t;

  // One-hot requester vector: bit0 VGA, bit1 GPU, bit2 LB.
  function automatic logic [2:0] arb_onehot(arb_id_t id);
    logic [2:0] oh;
    oh = 3'b000;
    case (id)
      ARB_VGA: oh = 3'b001;
      ARB_GPU: oh = 3'b010;
      ARB_LB:  oh = 3'b100;
      default: oh = 3'b000;
    endcase
    return oh;
  endfunction

endpackage

// File: rtl/syn_vcortex_arb_sel.sv
// Combinational grant selection: VGA first unless its burst limit is reached
// while someone else waits; GPU and LB share by round-robin.
module syn_vcortex_arb_sel
  import syn_vcortex_pkg::*;
#(
  parameter int VGA_BURST_MAX = 4
) (
  input  logic                   vga_req,
  input  logic                   gpu_req,
  input  logic                   lb_req,
  input  logic [BURST_CNT_W-1:0] burst_cnt,
  input  logic                   rr_ptr,      // 0 favours GPU, 1 favours LB
  output logic                   grant_valid,
  output arb_id_t                grant_id
);

  logic vga_capped;

  // Pick the winner among the currently asserted requests.
  always_comb begin
    vga_capped  = (burst_cnt == BURST_CNT_W'(VGA_BURST_MAX)) && (gpu_req || lb_req);
    grant_valid = vga_req || gpu_req || lb_req;
    grant_id    = ARB_VGA;
    if (vga_req && !vga_capped) begin
      grant_id = ARB_VGA;
    end else if (gpu_req && lb_req) begin
      grant_id = rr_ptr ? ARB_LB : ARB_GPU;
    end else if (gpu_req) begin
      grant_id = ARB_GPU;
    end else if (lb_req) begin
      grant_id = ARB_LB;
    end
  end

endmodule

// File: rtl/syn_vcortex_sram_arb.sv
// Three-way arbitrating controller for the external 256K x 16 async SRAM.
// Every granted access is a fixed two-cycle SRAM cycle (ACC then END); all
// pin outputs come straight from flops.
//
// Handshake: a requester raises <r>_req and holds req/addr/wdata stable until
// the edge that ends the cycle in which <r>_ack is high. ack is a single-cycle
// pulse; for reads, <r>_rd_valid pulses one cycle after ack with rd_data valid,
// and rd_data holds until the next read returned to that requester.
module syn_vcortex_sram_arb #(
  parameter int SRAM_ADDR_W   = 18,
  parameter int SRAM_DATA_W   = 16,
  parameter int VGA_BURST_MAX = 4
) (
  input  logic                   sys_clk_50,
  input  logic                   sys_rst,
  input  logic                   vga_req,
  input  logic [SRAM_ADDR_W-1:0] vga_addr,
  output logic                   vga_ack,
  output logic                   vga_rd_valid,
  output logic [SRAM_DATA_W-1:0] vga_rd_data,
  input  logic                   gpu_req,
  input  logic                   gpu_wr,
  input  logic [SRAM_ADDR_W-1:0] gpu_addr,
  input  logic [SRAM_DATA_W-1:0] gpu_wdata,
  output logic                   gpu_ack,
  output logic                   gpu_rd_valid,
  output logic [SRAM_DATA_W-1:0] gpu_rd_data,
  input  logic                   lb_req,
  input  logic                   lb_wr,
  input  logic [SRAM_ADDR_W-1:0] lb_addr,
  input  logic [SRAM_DATA_W-1:0] lb_wdata,
  output logic                   lb_ack,
  output logic                   lb_rd_valid,
  output logic [SRAM_DATA_W-1:0] lb_rd_data,
  output logic [SRAM_ADDR_W-1:0] sram_addr,
  output logic [SRAM_DATA_W-1:0] sram_wdata,
  output logic                   sram_dq_oe,
  input  logic [SRAM_DATA_W-1:0] sram_rdata,
  output logic                   sram_ce_n,
  output logic                   sram_oe_n,
  output logic                   sram_we_n,
  output logic                   sram_lb_n,
  output logic                   sram_ub_n,
  output logic [1:0]             dbg_state
);

  import syn_vcortex_pkg::arb_id_t;
  import syn_vcortex_pkg::ARB_VGA;
  import syn_vcortex_pkg::ARB_GPU;
  import syn_vcortex_pkg::ARB_LB;
  import syn_vcortex_pkg::sram_arb_fsm_t;
  import syn_vcortex_pkg::IDLE;
  import syn_vcortex_pkg::ACC;
  import syn_vcortex_pkg::END;
  import syn_vcortex_pkg::BURST_CNT_W;
  import syn_vcortex_pkg::arb_onehot;

  sram_arb_fsm_t          state_q, state_d;
  arb_id_t                owner_q, owner_d;
  logic                   wr_q, wr_d;
  logic [BURST_CNT_W-1:0] burst_cnt_q, burst_cnt_d;
  logic                   rr_q, rr_d;
  logic [2:0]             ack_q, ack_d;
  logic [2:0]             rd_valid_q, rd_valid_d;
  logic [SRAM_DATA_W-1:0] vga_rd_data_q, vga_rd_data_d;
  logic [SRAM_DATA_W-1:0] gpu_rd_data_q, gpu_rd_data_d;
  logic [SRAM_DATA_W-1:0] lb_rd_data_q, lb_rd_data_d;
  logic [SRAM_ADDR_W-1:0] addr_q, addr_d;
  logic [SRAM_DATA_W-1:0] wdata_q, wdata_d;
  logic                   dq_oe_q, dq_oe_d;
  logic                   ce_n_q, ce_n_d;
  logic                   oe_n_q, oe_n_d;
  logic                   we_n_q, we_n_d;
  logic                   bl_n_q, bl_n_d;

  logic                   grant_valid;
  arb_id_t                grant_id;
  logic                   sel_wr;
  logic [SRAM_ADDR_W-1:0] sel_addr;
  logic [SRAM_DATA_W-1:0] sel_wdata;

  syn_vcortex_arb_sel #(
    .VGA_BURST_MAX(VGA_BURST_MAX)
  ) u_arb_sel (
    .vga_req    (vga_req),
    .gpu_req    (gpu_req),
    .lb_req     (lb_req),
    .burst_cnt  (burst_cnt_q),
    .rr_ptr     (rr_q),
    .grant_valid(grant_valid),
    .grant_id   (grant_id)
  );

  // Route the winning requester's command fields.
  always_comb begin
    sel_wr    = 1'b0;
    sel_addr  = vga_addr;
    sel_wdata = wdata_q;
    case (grant_id)
      ARB_GPU: begin
        sel_wr    = gpu_wr;
        sel_addr  = gpu_addr;
        sel_wdata = gpu_wdata;
      end
      ARB_LB: begin
        sel_wr    = lb_wr;
        sel_addr  = lb_addr;
        sel_wdata = lb_wdata;
      end
      default: begin
        sel_wr    = 1'b0;
        sel_addr  = vga_addr;
        sel_wdata = wdata_q;
      end
    endcase
  end

  // Next-state: FSM, arbitration bookkeeping and registered SRAM pins.
  always_comb begin
    state_d       = state_q;
    owner_d       = owner_q;
    wr_d          = wr_q;
    burst_cnt_d   = burst_cnt_q;
    rr_d          = rr_q;
    ack_d         = 3'b000;
    rd_valid_d    = 3'b000;
    vga_rd_data_d = vga_rd_data_q;
    gpu_rd_data_d = gpu_rd_data_q;
    lb_rd_data_d  = lb_rd_data_q;
    addr_d        = addr_q;
    wdata_d       = wdata_q;
    dq_oe_d       = dq_oe_q;
    ce_n_d        = ce_n_q;
    oe_n_d        = oe_n_q;
    we_n_d        = we_n_q;
    bl_n_d        = bl_n_q;

    case (state_q)
      ACC: begin
        // Close the strobe; ce_n/addr/wdata/dq_oe stay for write hold.
        state_d = END;
        oe_n_d  = 1'b1;
        we_n_d  = 1'b1;
        if (!wr_q) begin
          rd_valid_d = arb_onehot(owner_q);
          case (owner_q)
            ARB_GPU: gpu_rd_data_d = sram_rdata;
            ARB_LB:  lb_rd_data_d  = sram_rdata;
            default: vga_rd_data_d = sram_rdata;
          endcase
        end
      end
      IDLE, END: begin
        // Arbitration slot: a VGA grant extends the burst, anything else ends it.
        if (grant_valid && grant_id == ARB_VGA) begin
          if (burst_cnt_q != BURST_CNT_W'(VGA_BURST_MAX)) begin
            burst_cnt_d = burst_cnt_q + 1'b1;
          end
        end else begin
          burst_cnt_d = '0;
        end
        if (grant_valid) begin
          state_d = ACC;
          owner_d = grant_id;
          wr_d    = sel_wr;
          ack_d   = arb_onehot(grant_id);
          addr_d  = sel_addr;
          ce_n_d  = 1'b0;
          bl_n_d  = 1'b0;
          oe_n_d  = sel_wr;
          we_n_d  = !sel_wr;
          dq_oe_d = sel_wr;
          if (sel_wr) begin
            wdata_d = sel_wdata;
          end
          if (grant_id != ARB_VGA) begin
            rr_d = !rr_q;
          end
        end else begin
          state_d = IDLE;
          ce_n_d  = 1'b1;
          bl_n_d  = 1'b1;
          oe_n_d  = 1'b1;
          we_n_d  = 1'b1;
          dq_oe_d = 1'b0;
        end
      end
      default: begin
        state_d = IDLE;
        ce_n_d  = 1'b1;
        bl_n_d  = 1'b1;
        oe_n_d  = 1'b1;
        we_n_d  = 1'b1;
        dq_oe_d = 1'b0;
      end
    endcase
  end

  // State registers; reset drops every strobe immediately, abandoning any access.
  always_ff @(posedge sys_clk_50 or posedge sys_rst) begin
    if (sys_rst) begin
      state_q       <= IDLE;
      owner_q       <= ARB_VGA;
      wr_q          <= 1'b0;
      burst_cnt_q   <= '0;
      rr_q          <= 1'b0;
      ack_q         <= 3'b000;
      rd_valid_q    <= 3'b000;
      vga_rd_data_q <= '0;
      gpu_rd_data_q <= '0;
      lb_rd_data_q  <= '0;
      addr_q        <= '0;
      wdata_q       <= '0;
      dq_oe_q       <= 1'b0;
      ce_n_q        <= 1'b1;
      oe_n_q        <= 1'b1;
      we_n_q        <= 1'b1;
      bl_n_q        <= 1'b1;
    end else begin
      state_q       <= state_d;
      owner_q       <= owner_d;
      wr_q          <= wr_d;
      burst_cnt_q   <= burst_cnt_d;
      rr_q          <= rr_d;
      ack_q         <= ack_d;
      rd_valid_q    <= rd_valid_d;
      vga_rd_data_q <= vga_rd_data_d;
      gpu_rd_data_q <= gpu_rd_data_d;
      lb_rd_data_q  <= lb_rd_data_d;
      addr_q        <= addr_d;
      wdata_q       <= wdata_d;
      dq_oe_q       <= dq_oe_d;
      ce_n_q        <= ce_n_d;
      oe_n_q        <= oe_n_d;
      we_n_q        <= we_n_d;
      bl_n_q        <= bl_n_d;
    end
  end

  assign vga_ack      = ack_q[0];
  assign gpu_ack      = ack_q[1];
  assign lb_ack       = ack_q[2];
  assign vga_rd_valid = rd_valid_q[0];
  assign gpu_rd_valid = rd_valid_q[1];
  assign lb_rd_valid  = rd_valid_q[2];
  assign vga_rd_data  = vga_rd_data_q;
  assign gpu_rd_data  = gpu_rd_data_q;
  assign lb_rd_data   = lb_rd_data_q;
  assign sram_addr    = addr_q;
  assign sram_wdata   = wdata_q;
  assign sram_dq_oe   = dq_oe_q;
  assign sram_ce_n    = ce_n_q;
  assign sram_oe_n    = oe_n_q;
  assign sram_we_n    = we_n_q;
  assign sram_lb_n    = bl_n_q;
  assign sram_ub_n    = bl_n_q;
  assign dbg_state    = state_q;

endmodule
